pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and sum width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4, pipeline depth; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset sampled on the clk rising edge.
REQ-005 Port in_valid, input, 1, operands and carry-in valid this cycle.
REQ-006 Port in_ready, output, 1, block accepts operands this cycle.
REQ-007 Port a, input, WIDTH, operand A.
REQ-008 Port b, input, WIDTH, operand B.
REQ-009 Port c_in, input, 1, carry-in.
REQ-010 Port out_valid, output, 1, result valid.
REQ-011 Port out_ready, input, 1, consumer accepts result.
REQ-012 Port sum, output, WIDTH, result bits (a + b + c_in) mod 2^WIDTH.
REQ-013 Port c_out, output, 1, carry out of bit WIDTH-1.
REQ-014 Port ovf, output, 1, two's-complement signed overflow; present only when ADDER_OVF_EN is defined.

Function
REQ-015 Operation SHALL be a ripple addition split into STAGES slices of SLICE = WIDTH/STAGES bits; slice k SHALL add bits [k*SLICE +: SLICE] in stage k using the carry registered out of stage k-1.
REQ-016 Each stage SHALL register: a valid bit, the unprocessed upper operand bits, the completed lower sum bits and the running carry.
REQ-017 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-018 Pipeline advance SHALL be global: advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational, no dependence on in_valid).
REQ-019 When advance = 0, all stage registers SHALL hold, and sum, c_out, ovf and out_valid SHALL remain stable.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid high when advance stays 1; throughput one result per cycle.
REQ-021 A cycle with in_valid = 0 and advance = 1 SHALL insert a bubble (stage valid 0); bubbles are not collapsed.
REQ-022 Stage-0 datapath contents SHALL be don't-care when its valid bit is 0; out_valid SHALL be the last stage's valid bit.
REQ-023 c_out SHALL equal bit WIDTH of the (WIDTH+1)-bit unsigned sum; wrap-around (e.g. all-ones + 1) SHALL give sum = 0, c_out = 1.
REQ-024 STAGES = 1 SHALL degenerate to a single registered adder with 1-cycle latency and identical handshake.

Reset
REQ-025 On rst = 1 all stage valid bits, out_valid, sum, c_out and ovf SHALL clear to 0 at the next clk edge; in_ready SHALL be 1 in the cycle after.
REQ-026 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear at the output after rst deasserts.
REQ-027 rst SHALL take priority over any simultaneous input or output transfer.

Configuration
REQ-028 Macro ADDER_OVF_EN defined: ovf port SHALL exist, ovf = carry into MSB XOR carry out of MSB, aligned with sum; the MSB operand sign bits SHALL be carried through the pipeline for this purpose.
REQ-029 Macro ADDER_OVF_EN undefined: ovf port and its pipeline bits SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package adder_pkg SHALL hold the WIDTH/STAGES defaults and a SLICE-width helper function; no other typedefs are needed.
REQ-031 Sub-module adder_slice (combinational, parametrised SLICE-bit ripple chain of one-bit full adders, carry in/out) SHALL be instantiated once per stage.

Verification
REQ-032 WIDTH=8, STAGES=2: a=0x3C, b=0x05, c_in=1, out_ready=1 -> after 2 cycles out_valid=1, sum=0x42, c_out=0.
REQ-033 WIDTH=8: a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1; with ADDER_OVF_EN, a=0x7F, b=0x01, c_in=0 -> sum=0x80, ovf=1.
REQ-034 Back-to-back 16 random inputs, out_ready=1 -> 16 results in order, one per cycle, matching a+b+c_in reference model.
REQ-035 out_ready held 0 for 5 cycles with pipeline full -> in_ready=0, sum/out_valid stable; on release results resume in order with no loss or duplication.
REQ-036 Assert rst with 2 operations in flight -> out_valid=0 next cycle, no stale result appears afterwards, in_ready=1.
REQ-037 STAGES=1 and STAGES=WIDTH builds: random traffic with random out_ready -> results match the model, latency 1 and WIDTH respectively.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults and helpers for the pipelined ripple adder.
// The optional overflow output is enabled by defining ADDER_OVF_EN.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Bits handled by each pipeline stage.
  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry chain of one-bit full adders.
module adder_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] sum,
  output logic             c_out
);

  logic [SLICE:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[SLICE];

endmodule

// File: rtl/pipelined_adder.sv
// Ripple adder split into STAGES registered slices with a valid/ready handshake.
// Define ADDER_OVF_EN to add the two's-complement overflow output ovf.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SLICE = slice_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  logic advance;

  // Stage registers: operands travel whole so the sign bits reach the last stage.
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];

  // Per-stage inputs (from the ports or the previous stage) and next values.
  logic             v_in  [STAGES];
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic             cy_in [STAGES];
  logic [WIDTH-1:0] s_nx  [STAGES];
  logic             c_nx  [STAGES];

  // One global stall: every stage moves only when the output can drain.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SLICE-1:0] slice_sum;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_head
      assign v_in[k]  = in_valid;
      assign a_in[k]  = a;
      assign b_in[k]  = b;
      assign s_in[k]  = '0;
      assign cy_in[k] = c_in;
    end else begin : g_link
      assign v_in[k]  = v_q[k-1];
      assign a_in[k]  = a_q[k-1];
      assign b_in[k]  = b_q[k-1];
      assign s_in[k]  = s_q[k-1];
      assign cy_in[k] = c_q[k-1];
    end

    adder_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .a    (a_in[k][k*SLICE +: SLICE]),
      .b    (b_in[k][k*SLICE +: SLICE]),
      .c_in (cy_in[k]),
      .sum  (slice_sum),
      .c_out(c_nx[k])
    );

    // NOTE: give every always_comb output a full default before any partial
    // update, otherwise untouched bits hold their value and a latch is inferred.
    always_comb begin
      merged                    = s_in[k];
      merged[k*SLICE +: SLICE]  = slice_sum;
    end

    assign s_nx[k] = merged;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Datapath flops are cleared too, so sum and c_out read 0 after reset.
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_nx[k];
        c_q[k] <= c_nx[k];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign c_out     = c_q[LAST];

`ifdef ADDER_OVF_EN
  // Carry into the MSB is a^b^sum there; overflow is that XOR the carry out.
  assign ovf = a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ s_q[LAST][WIDTH-1] ^ c_q[LAST];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: 8-bit adders with 2, 1 and 8 stages, scoreboard per instance.
// Define ADDER_OVF_EN to also check the overflow output.
module tb_pipelined_adder;

  localparam int W = 8;
  localparam int N = 3;
  localparam int EXP_LAT [N] = '{2, 1, 8};
`ifdef ADDER_OVF_EN
  localparam logic [W+1:0] CMP_MASK = '1;
`else
  localparam logic [W+1:0] CMP_MASK = {1'b0, {(W+1){1'b1}}};
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         in_valid_v  [N];
  logic         out_ready_v [N];
  logic         in_ready_v  [N];
  logic         out_valid_v [N];
  logic         c_out_v     [N];
  logic [W-1:0] sum_v       [N];
`ifdef ADDER_OVF_EN
  logic         ovf_v       [N];
`endif

  int checks = 0;
  int errors = 0;
  int out_cnt [N];

  // Scoreboards hold {ovf, c_out, sum} per instance.
  logic [W+1:0] q0[$];
  logic [W+1:0] q1[$];
  logic [W+1:0] q2[$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .sum(sum_v[0]), .c_out(c_out_v[0])
`ifdef ADDER_OVF_EN
    , .ovf(ovf_v[0])
`endif
  );

  pipelined_adder #(.WIDTH(W), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .sum(sum_v[1]), .c_out(c_out_v[1])
`ifdef ADDER_OVF_EN
    , .ovf(ovf_v[1])
`endif
  );

  pipelined_adder #(.WIDTH(W), .STAGES(W)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .sum(sum_v[2]), .c_out(c_out_v[2])
`ifdef ADDER_OVF_EN
    , .ovf(ovf_v[2])
`endif
  );

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] t;
    logic       o;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {o, t};
  endfunction

  function automatic logic [W+1:0] got_bits(input int i);
`ifdef ADDER_OVF_EN
    return {ovf_v[i], c_out_v[i], sum_v[i]};
`else
    return {1'b0, c_out_v[i], sum_v[i]};
`endif
  endfunction

  function automatic void sb_push(input int i, input logic [W+1:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int sb_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [W+1:0] sb_pop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Transfers are judged mid-cycle, half a period before the edge that commits them.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (out_valid_v[i] && out_ready_v[i]) begin
          logic [W+1:0] expv;
          logic [W+1:0] gotv;
          checks++;
          out_cnt[i]++;
          gotv = got_bits(i);
          if (sb_size(i) == 0) begin
            errors++;
            $display("FAIL unexpected_out inst %0d got {ovf,c_out,sum}=%h with empty scoreboard",
                     i, gotv);
          end else begin
            expv = sb_pop(i);
            if ((gotv & CMP_MASK) !== (expv & CMP_MASK)) begin
              errors++;
              $display("FAIL result inst %0d got {ovf,c_out,sum}=%h expected %h",
                       i, gotv & CMP_MASK, expv & CMP_MASK);
            end
          end
        end
        if (in_valid_v[i] && in_ready_v[i]) sb_push(i, model(a, b, c_in));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int i);
    int n;
    n = 0;
    while ((sb_size(i) != 0 || out_valid_v[i]) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb_size(i) != 0 || out_valid_v[i]) begin
      errors++;
      $display("FAIL drain inst %0d pending=%0d out_valid=%b expected empty", i, sb_size(i),
               out_valid_v[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_valid_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid inst %0d got %b expected 0", i, out_valid_v[i]);
      end
      checks++;
      if (in_ready_v[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready inst %0d got %b expected 1", i, in_ready_v[i]);
      end
      checks++;
      if (got_bits(i) !== '0) begin
        errors++;
        $display("FAIL reset_result inst %0d got %h expected 0", i, got_bits(i));
      end
    end
    rst = 1'b0;
    tick();
  endtask

  // One operation into inst 0, checking latency and the result at first out_valid.
  task automatic send_and_wait(input string name, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic ci,
                               input logic [W+1:0] exp_res);
    int n;
    a = x;
    b = y;
    c_in = ci;
    in_valid_v[0] = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    n = 1;
    while (!out_valid_v[0] && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != EXP_LAT[0]) begin
      errors++;
      $display("FAIL %s_latency got %0d expected %0d", name, n, EXP_LAT[0]);
    end
    checks++;
    if ((got_bits(0) & CMP_MASK) !== (exp_res & CMP_MASK)) begin
      errors++;
      $display("FAIL %s_value got %h expected %h", name, got_bits(0) & CMP_MASK,
               exp_res & CMP_MASK);
    end
    tick();
  endtask

  task automatic test_directed();
    send_and_wait("add_3c_05", 8'h3C, 8'h05, 1'b1, {1'b0, 1'b0, 8'h42});
    send_and_wait("wrap_ff_00", 8'hFF, 8'h00, 1'b1, {1'b0, 1'b1, 8'h00});
`ifdef ADDER_OVF_EN
    send_and_wait("ovf_7f_01", 8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80});
`endif
    wait_drain(0);
  endtask

  task automatic test_latency();
    int lat [N];
    int n;
    for (int i = 0; i < N; i++) lat[i] = 0;
    a = W'($urandom);
    b = W'($urandom);
    c_in = 1'($urandom);
    for (int i = 0; i < N; i++) in_valid_v[i] = 1'b1;
    tick();
    for (int i = 0; i < N; i++) in_valid_v[i] = 1'b0;
    n = 1;
    while (n < 30 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0)) begin
      for (int i = 0; i < N; i++) if (lat[i] == 0 && out_valid_v[i]) lat[i] = n;
      if (lat[0] == 0 || lat[1] == 0 || lat[2] == 0) begin
        tick();
        n++;
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lat[i] != EXP_LAT[i]) begin
        errors++;
        $display("FAIL latency inst %0d got %0d expected %0d", i, lat[i], EXP_LAT[i]);
      end
      wait_drain(i);
    end
  endtask

  task automatic test_back_to_back();
    int first;
    int last;
    int seen;
    first = -1;
    last  = -1;
    seen  = 0;
    for (int k = 0; k < 16 + EXP_LAT[0] + 3; k++) begin
      in_valid_v[0] = (k < 16);
      a = W'($urandom);
      b = W'($urandom);
      c_in = 1'($urandom);
      @(negedge clk);
      if (out_valid_v[0]) begin
        if (first < 0) first = k;
        last = k;
        seen++;
      end
      tick();
    end
    in_valid_v[0] = 1'b0;
    checks++;
    if (seen != 16) begin
      errors++;
      $display("FAIL b2b_count got %0d expected 16", seen);
    end
    checks++;
    if (last - first != 15) begin
      errors++;
      $display("FAIL b2b_contiguous got span %0d expected 15", last - first);
    end
    wait_drain(0);
  endtask

  task automatic test_stall();
    int n;
    logic [W+1:0] held;
    out_ready_v[0] = 1'b0;
    in_valid_v[0]  = 1'b1;
    n = 0;
    while (!out_valid_v[0] && n < 20) begin
      a = W'($urandom);
      b = W'($urandom);
      c_in = 1'($urandom);
      tick();
      n++;
    end
    checks++;
    if (!out_valid_v[0]) begin
      errors++;
      $display("FAIL stall_fill got out_valid=0 expected 1");
    end
    held = got_bits(0);
    for (int k = 0; k < 5; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      tick();
      checks++;
      if (in_ready_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready cycle %0d got %b expected 0", k, in_ready_v[0]);
      end
      checks++;
      if (out_valid_v[0] !== 1'b1) begin
        errors++;
        $display("FAIL stall_out_valid cycle %0d got %b expected 1", k, out_valid_v[0]);
      end
      checks++;
      if (got_bits(0) !== held) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got %h expected %h", k, got_bits(0), held);
      end
    end
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b1;
    wait_drain(0);
  endtask

  task automatic test_reset_flight();
    int seen;
    out_ready_v[0] = 1'b0;
    in_valid_v[0]  = 1'b1;
    in_valid_v[2]  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      c_in = 1'($urandom);
      tick();
    end
    in_valid_v[0] = 1'b0;
    in_valid_v[2] = 1'b0;
    rst = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (out_valid_v[i] !== 1'b0 || in_ready_v[i] !== 1'b1) begin
        errors++;
        $display("FAIL flight_reset inst %0d got out_valid=%b in_ready=%b expected 0/1", i,
                 out_valid_v[i], in_ready_v[i]);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) out_ready_v[i] = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      for (int i = 0; i < N; i++) if (out_valid_v[i]) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flight_stale got %0d stale outputs expected 0", seen);
    end
  endtask

  task automatic test_random_degenerate();
    for (int k = 0; k < 400; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      c_in = 1'($urandom);
      in_valid_v[1]  = 1'($urandom);
      in_valid_v[2]  = 1'($urandom);
      out_ready_v[1] = ($urandom_range(3, 0) != 0);
      out_ready_v[2] = ($urandom_range(3, 0) != 0);
      tick();
    end
    in_valid_v[1]  = 1'b0;
    in_valid_v[2]  = 1'b0;
    out_ready_v[1] = 1'b1;
    out_ready_v[2] = 1'b1;
    wait_drain(1);
    wait_drain(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    a    = '0;
    b    = '0;
    c_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b1;
      out_cnt[i]     = 0;
    end
    test_reset();
    test_directed();
    test_latency();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    test_random_degenerate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
